// File: rtl/serial_equality_controller.sv
// serial_equality_controller
// Compares two WIDTH-bit words through an external 1-bit equality detector,
// one bit pair per clock, LSB first. Reports word equality, the index of the
// lowest mismatching bit and the number of mismatching bits.
//
// Handshake: start is sampled only while idle (busy=0) and only when abort=0;
// a start while busy is dropped, not queued. done is a single-cycle pulse that
// marks equal/first_mismatch/mismatch_cnt valid. These results hold until the
// next accepted start. A new start may be issued in the same cycle done is
// high. abort ends a running compare with no done pulse.
module serial_equality_controller #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IW        = $clog2(WIDTH),
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             det_a,
  output logic             det_b,
  input  logic             det_eq,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IW-1:0]    first_mismatch,
  output logic [CW-1:0]    mismatch_cnt,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, a_nx;
  logic [WIDTH-1:0] b_sh, b_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic [IW-1:0]    fm_nx;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    cnt_inc;
  logic             eq_nx;
  logic             done_nx;
  logic             miss;

  // The detector always sees bit 0 of the shift registers; gated off when idle.
  assign busy      = (state == COMPARE);
  assign det_a     = busy & a_sh[0];
  assign det_b     = busy & b_sh[0];
  assign state_dbg = state;
  assign miss      = ~det_eq;
  assign cnt_inc   = mismatch_cnt + CW'(miss);

  // Next-state and next-result computation; all defaults hold current values.
  always_comb begin
    state_nx = state;
    a_nx     = a_sh;
    b_nx     = b_sh;
    idx_nx   = idx;
    fm_nx    = first_mismatch;
    cnt_nx   = mismatch_cnt;
    eq_nx    = equal;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          a_nx     = a_word;
          b_nx     = b_word;
          idx_nx   = '0;
          fm_nx    = '0;
          cnt_nx   = '0;
          eq_nx    = 1'b0;
          state_nx = COMPARE;
        end
      end
      COMPARE: begin
        if (abort) begin
          // Partial counters are kept; the bit on the detector this cycle is
          // not counted because the compare is being cancelled.
          eq_nx    = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
          if (miss && (mismatch_cnt == '0)) begin
            fm_nx = idx;
          end
          if (EARLY_EXIT && miss) begin
            eq_nx    = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else if (idx == IW'(WIDTH - 1)) begin
            eq_nx    = (cnt_inc == '0);
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + IW'(1);
            a_nx   = a_sh >> 1;
            b_nx   = b_sh >> 1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      a_sh           <= '0;
      b_sh           <= '0;
      idx            <= '0;
      first_mismatch <= '0;
      mismatch_cnt   <= '0;
      equal          <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nx;
      a_sh           <= a_nx;
      b_sh           <= b_nx;
      idx            <= idx_nx;
      first_mismatch <= fm_nx;
      mismatch_cnt   <= cnt_nx;
      equal          <= eq_nx;
      done           <= done_nx;
    end
  end

endmodule

// File: tb/tb_serial_equality_controller.sv
// Bench for serial_equality_controller: two instances share the requester
// inputs, one with early exit and one with full scan, each with its own
// equality detector model and its own expected-result queue.
module tb_serial_equality_controller;

  localparam int WIDTH = 8;
  localparam int IW    = 3;
  localparam int CW    = 4;
  localparam int RW    = 1 + IW + CW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;

  logic          det_a_fs, det_b_fs, det_eq_fs, busy_fs, done_fs, equal_fs, st_fs;
  logic [IW-1:0] fm_fs;
  logic [CW-1:0] cnt_fs;
  logic          det_a_ee, det_b_ee, det_eq_ee, busy_ee, done_ee, equal_ee, st_ee;
  logic [IW-1:0] fm_ee;
  logic [CW-1:0] cnt_ee;

  int vectors     = 0;
  int miscompares = 0;
  int done_fs_n   = 0;
  int done_ee_n   = 0;

  logic [RW-1:0] exp_fs_q[$];
  logic [RW-1:0] exp_ee_q[$];
  logic [RW-1:0] e_fs, e_ee;

  // Detector models: purely combinational equality of the presented bits.
  assign det_eq_fs = ~(det_a_fs ^ det_b_fs);
  assign det_eq_ee = ~(det_a_ee ^ det_b_ee);

  serial_equality_controller #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) u_fs (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_word(a_word), .b_word(b_word),
    .det_a(det_a_fs), .det_b(det_b_fs), .det_eq(det_eq_fs),
    .busy(busy_fs), .done(done_fs), .equal(equal_fs),
    .first_mismatch(fm_fs), .mismatch_cnt(cnt_fs), .state_dbg(st_fs)
  );

  serial_equality_controller #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_word(a_word), .b_word(b_word),
    .det_a(det_a_ee), .det_b(det_b_ee), .det_eq(det_eq_ee),
    .busy(busy_ee), .done(done_ee), .equal(equal_ee),
    .first_mismatch(fm_ee), .mismatch_cnt(cnt_ee), .state_dbg(st_ee)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full-scan monitor: pops and compares on every done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (done_fs) begin
        done_fs_n++;
        if (exp_fs_q.size() == 0) begin
          check("fs_unexpected_done", 1, 0);
        end else begin
          e_fs = exp_fs_q.pop_front();
          check("fs_equal", equal_fs, e_fs[RW-1]);
          check("fs_first_mismatch", fm_fs, e_fs[CW+IW-1:CW]);
          check("fs_mismatch_cnt", cnt_fs, e_fs[CW-1:0]);
        end
      end
    end
  end

  // Early-exit monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (done_ee) begin
        done_ee_n++;
        if (exp_ee_q.size() == 0) begin
          check("ee_unexpected_done", 1, 0);
        end else begin
          e_ee = exp_ee_q.pop_front();
          check("ee_equal", equal_ee, e_ee[RW-1]);
          check("ee_first_mismatch", fm_ee, e_ee[CW+IW-1:CW]);
          check("ee_mismatch_cnt", cnt_ee, e_ee[CW-1:0]);
        end
      end
    end
  end

  // One compare on both instances. Returns in the cycle the later done is
  // high. poke > 0 pulses start with zeroed operands at that cycle.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic eq_x, input logic [IW-1:0] fm_x,
                         input logic [CW-1:0] cnt_fs_x, input int lat_fs_x,
                         input logic [CW-1:0] cnt_ee_x, input int lat_ee_x,
                         input int poke);
    int lat, lf, le;
    logic [WIDTH-1:0] sa, sb;
    start  = 1'b1;
    a_word = a;
    b_word = b;
    exp_fs_q.push_back({eq_x, fm_x, cnt_fs_x});
    exp_ee_q.push_back({eq_x, fm_x, cnt_ee_x});
    step();
    start = 1'b0;
    sa = '0;
    sb = '0;
    sa[0] = det_a_fs;
    sb[0] = det_b_fs;
    lat = 0;
    lf  = -1;
    le  = -1;
    while ((lf < 0 || le < 0) && lat < 40) begin
      step();
      lat++;
      start = (lat == poke);
      if (lat == poke) begin
        a_word = '0;
        b_word = '0;
      end
      if (lat < WIDTH) begin
        sa[lat] = det_a_fs;
        sb[lat] = det_b_fs;
      end
      if (done_fs && lf < 0) lf = lat;
      if (done_ee && le < 0) le = lat;
    end
    start = 1'b0;
    check("fs_latency", lf, lat_fs_x);
    check("ee_latency", le, lat_ee_x);
    check("fs_det_a_seq", sa, a);
    check("fs_det_b_seq", sb, b);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int nd;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    a_word = '0;
    b_word = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_fs, 0);
    check("rst_done", done_fs, 0);
    check("rst_equal", equal_fs, 0);
    check("rst_fm", fm_fs, 0);
    check("rst_cnt", cnt_fs, 0);
    check("rst_det_a", det_a_fs, 0);
    check("rst_det_b", det_b_fs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // a, b, equal, first_mismatch, cnt/lat full scan, cnt/lat early exit, poke
    run_cmp(8'hA5, 8'hA5, 1'b1, 3'd0, 4'd0, 8, 4'd0, 8, 0);
    run_cmp(8'hA5, 8'hA4, 1'b0, 3'd0, 4'd1, 8, 4'd1, 1, 0);
    run_cmp(8'hFF, 8'h0F, 1'b0, 3'd4, 4'd4, 8, 4'd1, 5, 0);
    run_cmp(8'h5A, 8'hA5, 1'b0, 3'd0, 4'd8, 8, 4'd1, 1, 0);
    run_cmp(8'h01, 8'h03, 1'b0, 3'd1, 4'd1, 8, 4'd1, 2, 0);
    run_cmp(8'h3C, 8'h3C, 1'b1, 3'd0, 4'd0, 8, 4'd0, 8, 3);
    // Issued in the done cycle of the previous compare.
    run_cmp(8'h80, 8'h00, 1'b0, 3'd7, 4'd1, 8, 4'd1, 8, 0);

    // Abort at cycle 4 of a compare.
    step();
    start  = 1'b1;
    a_word = 8'h55;
    b_word = 8'h55;
    step();
    start = 1'b0;
    repeat (4) step();
    check("abort_busy_before", busy_fs, 1);
    nd = done_fs_n + done_ee_n;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy_fs", busy_fs, 0);
    check("abort_busy_ee", busy_ee, 0);
    check("abort_equal", equal_fs, 0);
    check("abort_done", done_fs, 0);
    repeat (10) step();
    check("abort_no_done", done_fs_n + done_ee_n, nd);

    // start with abort in IDLE is ignored.
    start  = 1'b1;
    abort  = 1'b1;
    a_word = 8'h11;
    b_word = 8'h11;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy_fs", busy_fs, 0);
    check("start_abort_busy_ee", busy_ee, 0);
    repeat (10) step();
    check("start_abort_no_done", done_fs_n + done_ee_n, nd);

    // Asynchronous reset in the middle of a compare.
    start  = 1'b1;
    a_word = 8'hFE;
    b_word = 8'hFF;
    exp_ee_q.push_back({1'b0, 3'd0, 4'd1});
    step();
    start = 1'b0;
    repeat (3) step();
    check("mid_busy_before", busy_fs, 1);
    check("mid_cnt_before", cnt_fs, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_fs, 0);
    check("mid_rst_done", done_fs, 0);
    check("mid_rst_equal", equal_fs, 0);
    check("mid_rst_fm", fm_fs, 0);
    check("mid_rst_cnt_fs", cnt_fs, 0);
    check("mid_rst_cnt_ee", cnt_ee, 0);
    check("mid_rst_det_a", det_a_fs, 0);
    check("mid_rst_det_b", det_b_fs, 0);
    check("mid_rst_state", st_fs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_cmp(8'hFF, 8'hFF, 1'b1, 3'd0, 4'd0, 8, 4'd0, 8, 0);

    repeat (3) step();
    check("fs_queue_empty", exp_fs_q.size(), 0);
    check("ee_queue_empty", exp_ee_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
